// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - md_op encodings, sequencer states and op-class decode for the md unit
// MD_SEQUENCER_MADD_EN adds the madd/maddu/msub/msubu codes to the multiply class.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NOP   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  function automatic logic is_mult_op(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU: return 1'b1;
`ifdef MD_SEQUENCER_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational 64-bit product and quotient/remainder of the latched operands
module md_arith
  import md_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic        sgn;
  logic [63:0] a_ext, b_ext;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;

  assign sgn   = is_signed_op(op);
  assign a_ext = {{32{sgn & a[31]}}, a};
  assign b_ext = {{32{sgn & b[31]}}, b};
  // Low 64 bits of the sign-extended product are the two's-complement result.
  assign prod  = a_ext * b_ext;

  assign div_zero = (b == 32'd0);
  assign a_neg    = sgn & a[31];
  assign b_neg    = sgn & b[31];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;

  always_comb begin
    q_mag = '0;
    r_mag = '0;
    if (!div_zero) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
  end

  // Magnitude divide then sign fix: quotient truncates toward zero, remainder follows dividend.
  assign quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem  = a_neg ? -r_mag : r_mag;

endmodule

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multi-cycle mult/div sequencer owning HI/LO; MD_SEQUENCER_MADD_EN adds madd/msub
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        start,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  md_state_e   state;
  logic [3:0]  cnt;
  logic [31:0] a_q, b_q;
  logic [3:0]  op_q;
  logic        issue_mult, issue_div;
  logic [63:0] prod, mult_res;
  logic [31:0] quot, rem;
  logic        div_zero;

  assign issue_mult = is_mult_op(md_op);
  assign issue_div  = is_div_op(md_op);
  assign start      = issue_mult | issue_div;
  assign md_stall   = start | busy;

  md_arith u_arith (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

`ifdef MD_SEQUENCER_MADD_EN
  // Accumulate against HI/LO as they stand at commit, wrapping modulo 2^64.
  always_comb begin
    mult_res = prod;
    case (op_q)
      MD_MADD, MD_MADDU: mult_res = {hi, lo} + prod;
      MD_MSUB, MD_MSUBU: mult_res = {hi, lo} - prod;
      default:           mult_res = prod;
    endcase
  end
`else
  assign mult_res = prod;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue_mult) begin
            a_q   <= rs_data;
            b_q   <= rt_data;
            op_q  <= md_op;
            cnt   <= 4'(MULT_CYCLES);
            busy  <= 1'b1;
            state <= ST_MULT;
          end else if (issue_div) begin
            a_q   <= rs_data;
            b_q   <= rt_data;
            op_q  <= md_op;
            cnt   <= 4'(DIV_CYCLES);
            busy  <= 1'b1;
            state <= ST_DIV;
          end else if (md_op == MD_MTHI) begin
            hi <= rs_data;
          end else if (md_op == MD_MTLO) begin
            lo <= rs_data;
          end
        end
        ST_MULT, ST_DIV: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
            if (state == ST_MULT) begin
              {hi, lo} <= mult_res;
            end else if (!div_zero) begin
              hi <= rem;
              lo <= quot;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - randomized and directed bench for md_sequencer against an arithmetic reference model
module tb_md_sequencer;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] rs_data, rt_data;
  logic        busy, start, md_stall, done;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .busy     (busy),
    .start    (start),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo),
    .done     (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int op_cycles(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU: return MC;
      OP_DIV, OP_DIVU:   return DC;
`ifdef MD_SEQUENCER_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return MC;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic model_commit(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    case (op)
      OP_MULT:  {m_hi, m_lo} = 64'(sa * sb);
      OP_MULTU: {m_hi, m_lo} = up;
      OP_DIV:   if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      OP_DIVU:  if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      OP_MADD:  {m_hi, m_lo} = {m_hi, m_lo} + 64'(sa * sb);
      OP_MADDU: {m_hi, m_lo} = {m_hi, m_lo} + up;
      OP_MSUB:  {m_hi, m_lo} = {m_hi, m_lo} - 64'(sa * sb);
      OP_MSUBU: {m_hi, m_lo} = {m_hi, m_lo} - up;
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = op_cycles(op);
    md_op = op; rs_data = a; rt_data = b;
    #1;
    check("start", start, n > 0);
    check("stall_issue", md_stall, n > 0);
    tick();
    md_op = OP_NOP;
    if (n == 0) begin
      if (op == OP_MTHI) m_hi = a;
      else if (op == OP_MTLO) m_lo = a;
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_hi", hi, m_hi);
      check("idle_lo", lo, m_lo);
    end else begin
      for (int i = 0; i < n; i++) begin
        check("busy", busy, 1);
        check("stall", md_stall, 1);
        check("done_early", done, 0);
        check("hold_hi", hi, m_hi);
        check("hold_lo", lo, m_lo);
        tick();
      end
      model_commit(op, a, b);
      check("busy_drop", busy, 0);
      check("done_pulse", done, 1);
      check("commit_hi", hi, m_hi);
      check("commit_lo", lo, m_lo);
      tick();
      check("done_clear", done, 0);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; md_op = OP_NOP; rs_data = '0; rt_data = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_stall", md_stall, 0);
    reset = 1'b0;

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFF1);
    run_op(OP_DIVU, 32'd7, 32'd2);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    run_op(OP_MTHI, 32'h1234_5678, 32'd0);
    run_op(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
    check("mthi_val", hi, 32'h1234_5678);
    check("mtlo_val", lo, 32'h9ABC_DEF0);

    run_op(OP_MTHI, 32'h0000_AAAA, 32'd0);
    run_op(OP_MTLO, 32'h0000_5555, 32'd0);
    run_op(OP_DIV, 32'd1234, 32'd0);
    check("dz_hi", hi, 32'h0000_AAAA);
    check("dz_lo", lo, 32'h0000_5555);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);

    // mtlo issued in the second busy cycle of a mult must be dropped
    md_op = OP_MULT; rs_data = 32'd7; rt_data = 32'd9;
    tick();
    md_op = OP_NOP;
    tick();
    md_op = OP_MTLO; rs_data = 32'h0000_DEAD;
    #1;
    check("ign_stall", md_stall, 1);
    check("ign_busy", busy, 1);
    tick();
    md_op = OP_NOP;
    for (int i = 0; i < MC - 2; i++) begin
      check("ign_stall_run", md_stall, 1);
      tick();
    end
    m_hi = 32'd0; m_lo = 32'd63;
    check("ign_lo", lo, m_lo);
    check("ign_hi", hi, m_hi);
    check("ign_done", done, 1);
    tick();

    // reset in the fourth busy cycle of a div aborts without commit
    md_op = OP_DIV; rs_data = 32'd100; rt_data = 32'd7;
    tick();
    md_op = OP_NOP;
    tick(); tick(); tick();
    check("abort_busy_pre", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_done", done, 0);
    for (int i = 0; i < DC; i++) begin
      check("abort_no_done", done, 0);
      check("abort_no_commit", lo, 0);
      tick();
    end

`ifdef MD_SEQUENCER_MADD_EN
    run_op(OP_MTHI, 32'd0, 32'd0);
    run_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
    run_op(OP_MADDU, 32'd1, 32'd1);
    check("maddu_hi", hi, 32'd1);
    check("maddu_lo", lo, 32'd0);
`else
    run_op(OP_MADDU, 32'd1, 32'd1);
    check("madd_off_busy", busy, 0);
`endif

    for (int k = 0; k < 60; k++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = pick_operand();
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_operand();
      run_op(op, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
